// File: rtl/pseudo_spi_capt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pseudo_spi_capt_pkg
//  Purpose  : Shared definitions for the pseudo-SPI capture block. Holds the
//             capture FSM encoding, the default SRAM/word widths and the
//             encodings of the companion serial-out interface so that both
//             directions of the analog link agree on one header.
//  Revision : 1.0 - initial release
// ============================================================================
package pseudo_spi_capt_pkg;

    // Default widths of the SRAM port and of one captured word
    localparam int DEF_MEMORY_DATA_WIDTH = 8;
    localparam int DEF_MEMORY_ADDR_WIDTH = 9;
    localparam int DEF_RESERVED_DATA_LEN = 8;

    // Widths of the word-count and phase-stretch inputs
    localparam int LEN_W = 8;
    localparam int DIV_W = 8;

    // Capture FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_SCK2  = 3'd2,
        ST_GAP2  = 3'd3,
        ST_SCK1  = 3'd4,
        ST_GAP1  = 3'd5,
        ST_WRITE = 3'd6,
        ST_DONE  = 3'd7
    } capt_state_e;

    // Serial-out interface states (used by the transmit side of the link)
    typedef enum logic [1:0] {
        SO_IDLE  = 2'd0,
        SO_LOAD  = 2'd1,
        SO_SHIFT = 2'd2,
        SO_DONE  = 2'd3
    } so_state_e;

endpackage : pseudo_spi_capt_pkg
`default_nettype wire

// File: rtl/pseudo_spi_capt.sv
`default_nettype none
// ============================================================================
//  Module   : pseudo_spi_capt
//  Purpose  : Captures DATA_LEN serial words from an analog device and writes
//             them to an SRAM at descending addresses. One LAT strobe loads
//             the device, then each bit is clocked with a non-overlapping
//             SCLK2 / SCLK1 pair, each phase stretched to H = FREQ_DIV+1.
//  Ports    : CLK, RST_N (async, active low)
//             BGN         - level start, dropping it aborts
//             ADDR_BGN    - first SRAM address (counts down)
//             DATA_LEN    - number of words, 0 goes straight to done
//             FREQ_DIV    - phase stretch
//             SPI_SI      - serial data in, LSB first
//             SCLK1/SCLK2 - shift clocks, LAT - parallel-load strobe
//             A, CEN, D_WE, PO - SRAM write port (CEN/D_WE active low)
//             spi_is_done - held high until BGN is released
//  Revision : 1.0 - initial release
// ============================================================================
module pseudo_spi_capt
    import pseudo_spi_capt_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = DEF_MEMORY_DATA_WIDTH,
    parameter int MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH,
    parameter int RESERVED_DATA_LEN = DEF_RESERVED_DATA_LEN
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         BGN,
    input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
    input  logic [LEN_W-1:0]             DATA_LEN,
    input  logic [DIV_W-1:0]             FREQ_DIV,
    input  logic                         SPI_SI,
    output logic                         SCLK1,
    output logic                         SCLK2,
    output logic                         LAT,
    output logic [MEMORY_ADDR_WIDTH-1:0] A,
    output logic                         CEN,
    output logic                         D_WE,
    output logic [MEMORY_DATA_WIDTH-1:0] PO,
    output logic                         spi_is_done
);

    localparam int BIT_W = (RESERVED_DATA_LEN > 1) ? $clog2(RESERVED_DATA_LEN) : 1;
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(RESERVED_DATA_LEN - 1);

    capt_state_e                    r_state;
    capt_state_e                    w_nxt;
    logic [DIV_W-1:0]               r_div;
    logic [DIV_W-1:0]               r_cnt;
    logic [LEN_W-1:0]               r_words;
    logic [BIT_W-1:0]               r_bit;
    logic [MEMORY_ADDR_WIDTH-1:0]   r_addr;
    logic [RESERVED_DATA_LEN-1:0]   r_shift;
    logic                           w_phase_end;
    logic [MEMORY_DATA_WIDTH-1:0]   w_word;

    logic                           r_sclk1;
    logic                           r_sclk2;
    logic                           r_lat;
    logic                           r_cen;
    logic                           r_dwe;
    logic [MEMORY_ADDR_WIDTH-1:0]   r_a;
    logic [MEMORY_DATA_WIDTH-1:0]   r_po;
    logic                           r_done;

    // Captured word resized to the SRAM word width
    assign w_word      = MEMORY_DATA_WIDTH'(r_shift);
    // Last cycle of an H-cycle phase (LATCH, SCK2, SCK1)
    assign w_phase_end = (r_cnt == r_div);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (BGN) w_nxt = (DATA_LEN == '0) ? ST_DONE : ST_LATCH;
            ST_LATCH: if (w_phase_end) w_nxt = ST_SCK2;
            ST_SCK2:  if (w_phase_end) w_nxt = ST_GAP2;
            ST_GAP2:  w_nxt = ST_SCK1;
            ST_SCK1:  if (w_phase_end) w_nxt = ST_GAP1;
            ST_GAP1:  w_nxt = (r_bit == C_LAST_BIT) ? ST_WRITE : ST_SCK2;
            ST_WRITE: w_nxt = (r_words == LEN_W'(1)) ? ST_DONE : ST_SCK2;
            ST_DONE:  w_nxt = ST_DONE;
            default:  w_nxt = ST_IDLE;
        endcase
        // Releasing BGN anywhere outside IDLE abandons the transfer; DONE
        // uses the same path to return to IDLE.
        if ((r_state != ST_IDLE) && !BGN) begin
            w_nxt = ST_IDLE;
        end
    end

    // Outputs are registered from the next state so they line up exactly
    // with the cycles spent in each state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_words <= '0;
            r_bit   <= '0;
            r_addr  <= '0;
            r_shift <= '0;
            r_sclk1 <= 1'b0;
            r_sclk2 <= 1'b0;
            r_lat   <= 1'b0;
            r_cen   <= 1'b1;
            r_dwe   <= 1'b1;
            r_a     <= '0;
            r_po    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;

            // Phase counter restarts on every state change
            r_cnt <= (w_nxt != r_state) ? '0 : r_cnt + DIV_W'(1);

            if ((r_state == ST_IDLE) && BGN) begin
                r_div   <= FREQ_DIV;
                r_words <= DATA_LEN;
                r_addr  <= ADDR_BGN;
                r_bit   <= '0;
            end

            // Sample on the edge that closes the last SCLK1 cycle
            if ((r_state == ST_SCK1) && w_phase_end) begin
                r_shift <= {SPI_SI, r_shift[RESERVED_DATA_LEN-1:1]};
            end

            if ((r_state == ST_GAP1) && (w_nxt == ST_SCK2)) begin
                r_bit <= r_bit + BIT_W'(1);
            end

            if (r_state == ST_WRITE) begin
                r_addr  <= r_addr - MEMORY_ADDR_WIDTH'(1);
                r_words <= r_words - LEN_W'(1);
                r_bit   <= '0;
            end

            r_sclk1 <= (w_nxt == ST_SCK1);
            r_sclk2 <= (w_nxt == ST_SCK2);
            r_lat   <= (w_nxt == ST_LATCH);
            r_cen   <= (w_nxt != ST_WRITE);
            r_dwe   <= (w_nxt != ST_WRITE);
            r_a     <= (w_nxt == ST_WRITE) ? r_addr : '0;
            if (w_nxt == ST_WRITE) begin
                r_po <= w_word;
            end
            r_done  <= (w_nxt == ST_DONE);
        end
    end

    assign SCLK1       = r_sclk1;
    assign SCLK2       = r_sclk2;
    assign LAT         = r_lat;
    assign CEN         = r_cen;
    assign D_WE        = r_dwe;
    assign A           = r_a;
    assign PO          = r_po;
    assign spi_is_done = r_done;

endmodule : pseudo_spi_capt
`default_nettype wire

// File: tb/tb_pseudo_spi_capt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pseudo_spi_capt
//  Purpose  : Self-checking bench for pseudo_spi_capt. A behavioural analog
//             device shifts a word stream out LSB first, advancing one bit
//             on each SCLK1 fall; writes and strobe timing are compared
//             against expectations computed from the transfer rules.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pseudo_spi_capt;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int RL = 8;

    logic          CLK      = 1'b0;
    logic          RST_N    = 1'b0;
    logic          BGN      = 1'b0;
    logic [AW-1:0] ADDR_BGN = '0;
    logic [7:0]    DATA_LEN = '0;
    logic [7:0]    FREQ_DIV = '0;
    logic          SPI_SI   = 1'b0;
    logic          SCLK1, SCLK2, LAT, CEN, D_WE, spi_is_done;
    logic [AW-1:0] A;
    logic [DW-1:0] PO;

    pseudo_spi_capt #(
        .MEMORY_DATA_WIDTH (DW),
        .MEMORY_ADDR_WIDTH (AW),
        .RESERVED_DATA_LEN (RL)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .BGN         (BGN),
        .ADDR_BGN    (ADDR_BGN),
        .DATA_LEN    (DATA_LEN),
        .FREQ_DIV    (FREQ_DIV),
        .SPI_SI      (SPI_SI),
        .SCLK1       (SCLK1),
        .SCLK2       (SCLK2),
        .LAT         (LAT),
        .A           (A),
        .CEN         (CEN),
        .D_WE        (D_WE),
        .PO          (PO),
        .spi_is_done (spi_is_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Continuous non-overlap watch over the whole run
    int overlap_cycles = 0;
    always @(negedge CLK) if (SCLK1 && SCLK2) overlap_cycles++;

    // Observations of the last transfer
    logic [7:0] src_w[$];
    int wr_a[$];
    int wr_d[$];
    int done_post, lat_cyc, lat_rise, s2_rise, slot;
    int s1_min, s1_max, s2_min, s2_max;
    int idle_bad, we_bad, done_drop;
    bit done_seen;

    typedef struct {
        int addr;
        int len;
        int div;
        int w0;
        int w1;
        int w2;
        int exp_post;   // edges from the IDLE exit to spi_is_done
    } vec_t;
    vec_t tv[5];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic src_bit(input int idx);
        logic [7:0] w;
        if ((idx / 8) < src_w.size()) begin
            w = src_w[idx / 8];
            return w[idx % 8];
        end
        return 1'b0;
    endfunction

    task automatic set_words(input int n, input int w0, input int w1, input int w2);
        src_w.delete();
        if (n > 0) src_w.push_back(8'(w0));
        if (n > 1) src_w.push_back(8'(w1));
        if (n > 2) src_w.push_back(8'(w2));
    endtask

    // Runs one transfer. abort_rise>0 drops BGN on that SCLK2 rise; hold is
    // the number of cycles BGN stays high after done (or runs after abort).
    task automatic run_xfer(input int addr, input int len, input int div,
                            input int abort_rise, input int hold);
        int n, bit_idx, last_rise, run1, run2, abort_n, done_n;
        bit p1, p2, pl, fin;
        wr_a.delete(); wr_d.delete();
        done_post = -1; lat_cyc = 0; lat_rise = 0; s2_rise = 0; slot = -1;
        s1_min = 1 << 30; s1_max = 0; s2_min = 1 << 30; s2_max = 0;
        idle_bad = 0; we_bad = 0; done_drop = 0; done_seen = 0;
        @(negedge CLK);
        ADDR_BGN = AW'(addr); DATA_LEN = 8'(len); FREQ_DIV = 8'(div); BGN = 1'b1;
        bit_idx = 0; SPI_SI = src_bit(0);
        n = 0; last_rise = -1; run1 = 0; run2 = 0; abort_n = -1; done_n = -1;
        p1 = 0; p2 = 0; pl = 0; fin = 0;
        while (!fin && n < 20000) begin
            @(negedge CLK);
            n++;
            // Parameter inputs are meaningless once the transfer has started
            ADDR_BGN = AW'($urandom); DATA_LEN = 8'($urandom); FREQ_DIV = 8'($urandom);
            if (!CEN) begin
                wr_a.push_back(int'(A));
                wr_d.push_back(int'(PO));
                if (D_WE !== 1'b0) we_bad++;
            end else if (D_WE !== 1'b1 || A !== '0) begin
                idle_bad++;
            end
            if (LAT) lat_cyc++;
            if (LAT && !pl) lat_rise++;
            if (SCLK2 && !p2) begin
                s2_rise++;
                if (last_rise >= 0 && slot < 0) slot = n - last_rise;
                last_rise = n;
            end
            if (SCLK2) run2++;
            else if (p2) begin
                if (run2 < s2_min) s2_min = run2;
                if (run2 > s2_max) s2_max = run2;
                run2 = 0;
            end
            if (SCLK1) run1++;
            else if (p1) begin
                if (run1 < s1_min) s1_min = run1;
                if (run1 > s1_max) s1_max = run1;
                run1 = 0;
            end
            if (p1 && !SCLK1) bit_idx++;
            SPI_SI = src_bit(bit_idx);
            p1 = SCLK1; p2 = SCLK2; pl = LAT;

            if (spi_is_done && !done_seen) begin
                done_seen = 1; done_post = n - 1; done_n = n;
            end
            if (abort_n < 0 && abort_rise > 0 && s2_rise == abort_rise && BGN) begin
                BGN = 1'b0;
                abort_n = n;
            end else if (abort_n >= 0) begin
                if (n == abort_n + 1)
                    chk("abort_idle_next", {SCLK1, SCLK2, LAT, ~CEN}, 0);
                if (n >= abort_n + hold) fin = 1;
            end else if (done_seen) begin
                if (n <= done_n + hold && !spi_is_done) done_drop++;
                if (n == done_n + hold) BGN = 1'b0;
                else if (n > done_n + hold) begin
                    chk("done_clears", spi_is_done, 0);
                    fin = 1;
                end
            end
        end
        if (!fin) chk("xfer_timeout", 1, 0);
    endtask

    task automatic check_normal(input string tag, input int addr, input int len,
                                input int div, input int exp_post);
        int h;
        h = div + 1;
        chk({tag, ".done_post"}, done_post, exp_post);
        chk({tag, ".writes"}, wr_a.size(), len);
        for (int i = 0; i < len && i < wr_a.size(); i++) begin
            chk({tag, ".addr"}, wr_a[i], (((addr - i) % 512) + 512) % 512);
            chk({tag, ".data"}, wr_d[i], int'(src_w[i]));
        end
        chk({tag, ".lat_cycles"}, lat_cyc, (len > 0) ? h : 0);
        chk({tag, ".lat_pulses"}, lat_rise, (len > 0) ? 1 : 0);
        chk({tag, ".sclk2_pulses"}, s2_rise, RL * len);
        if (len > 0) begin
            chk({tag, ".sclk1_min"}, s1_min, h);
            chk({tag, ".sclk1_max"}, s1_max, h);
            chk({tag, ".sclk2_min"}, s2_min, h);
            chk({tag, ".sclk2_max"}, s2_max, h);
            chk({tag, ".bit_slot"}, slot, 2 * h + 2);
        end
        chk({tag, ".idle_port"}, idle_bad, 0);
        chk({tag, ".we_in_write"}, we_bad, 0);
        chk({tag, ".done_held"}, done_drop, 0);
    endtask

    initial begin
        int addr, len, div, h, w;

        tv[0] = '{addr: 'h010, len: 1, div: 0, w0: 'hA5, w1: 0,     w2: 0,     exp_post: 34};
        tv[1] = '{addr: 'h001, len: 3, div: 0, w0: 'h11, w1: 'h22,  w2: 'h33,  exp_post: 100};
        tv[2] = '{addr: 'h0AB, len: 1, div: 3, w0: 'h5A, w1: 0,     w2: 0,     exp_post: 85};
        tv[3] = '{addr: 'h055, len: 0, div: 5, w0: 0,    w1: 0,     w2: 0,     exp_post: 0};
        tv[4] = '{addr: 'h1FF, len: 2, div: 1, w0: 'hC3, w1: 'h3C,  w2: 0,     exp_post: 100};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst.sclk1", SCLK1, 0);
        chk("rst.sclk2", SCLK2, 0);
        chk("rst.lat", LAT, 0);
        chk("rst.cen", CEN, 1);
        chk("rst.dwe", D_WE, 1);
        chk("rst.a", A, 0);
        chk("rst.po", PO, 0);
        chk("rst.done", spi_is_done, 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed table
        for (int i = 0; i < 5; i++) begin
            set_words(tv[i].len, tv[i].w0, tv[i].w1, tv[i].w2);
            run_xfer(tv[i].addr, tv[i].len, tv[i].div, 0, 3);
            check_normal($sformatf("vec%0d", i), tv[i].addr, tv[i].len, tv[i].div,
                         tv[i].exp_post);
        end

        // Randomized transfers against the timing/write model
        for (int k = 0; k < 6; k++) begin
            addr = $urandom_range(0, 511);
            len  = $urandom_range(1, 3);
            div  = $urandom_range(0, 2);
            set_words(len, $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255));
            h = div + 1;
            run_xfer(addr, len, div, 0, 2);
            check_normal($sformatf("rnd%0d", k), addr, len, div, h + len * (RL * (2 * h + 2) + 1));
        end

        // Abort during bit 4 of word 2 of 3
        set_words(3, 'h6E, 'h91, 'h47);
        run_xfer('h100, 3, 0, RL + 4 + 1, 40);
        chk("abort.writes", wr_a.size(), 1);
        if (wr_a.size() > 0) begin
            chk("abort.addr", wr_a[0], 'h100);
            chk("abort.data", wr_d[0], 'h6E);
        end
        chk("abort.done_never", done_seen, 0);

        // Asynchronous reset in the middle of an SCLK1 phase
        set_words(2, 'h99, 'h66, 0);
        @(negedge CLK);
        ADDR_BGN = AW'('h020); DATA_LEN = 8'd2; FREQ_DIV = 8'd1; BGN = 1'b1;
        SPI_SI = 1'b1;
        w = 0;
        while (!SCLK1 && w < 200) begin
            @(negedge CLK);
            w++;
        end
        chk("reset_seq.reached_sck1", SCLK1, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("async_rst.sclk1", SCLK1, 0);
        chk("async_rst.sclk2", SCLK2, 0);
        chk("async_rst.lat", LAT, 0);
        chk("async_rst.cen", CEN, 1);
        chk("async_rst.dwe", D_WE, 1);
        chk("async_rst.a", A, 0);
        chk("async_rst.po", PO, 0);
        chk("async_rst.done", spi_is_done, 0);
        BGN = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk("post_rst.idle", {SCLK1, SCLK2, LAT, ~CEN, spi_is_done}, 0);
        run_xfer('h020, 2, 1, 0, 2);
        check_normal("post_rst", 'h020, 2, 1, 2 + 2 * (RL * 6 + 1));

        chk("sclk_overlap", overlap_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pseudo_spi_capt
`default_nettype wire
